edusoc_fetch: RTL and testbench

Instruction-fetch front end for a CPU core attached to the EduSoC instruction port. It drives the SoC's instruction request handshake (`INSTR_REQ`/`INSTR_ADDR`, `INSTR_VALID`/`INSTR_RDATA`) and buffers fetched words in a small prefetch FIFO. It presents them in order to the core's decode stage via a valid/ready handshake, and supports pipeline redirects (branch/jump/trap) that flush the buffer and discard in-flight stale responses.

---
 rtl/edusoc_fetch.sv | 157 +++++++++++++++
 tb/tb_edusoc_fetch.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/edusoc_fetch.sv
// rtl/edusoc_fetch.sv - EduSoC instruction-fetch front end with prefetch FIFO and redirect
module edusoc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RES,
  output logic        INSTR_REQ,
  output logic [31:0] INSTR_ADDR,
  input  logic        INSTR_VALID,
  input  logic [31:0] INSTR_RDATA,
  output logic        DEC_VALID,
  input  logic        DEC_READY,
  output logic [31:0] DEC_PC,
  output logic [31:0] DEC_INSTR,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  state_t           state, state_next;
  logic [31:0]      fetch_pc;
  logic [31:0]      mem_pc    [DEPTH];
  logic [31:0]      mem_instr [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0]   count, count_next;
  logic             push, pop, has_space;
  logic [31:0]      redirect_target, addr_plus4;
  logic             addr_load, pc_load;
  logic [31:0]      addr_next, pc_next;

  assign redirect_target = REDIRECT_PC & 32'hFFFF_FFFC;
  assign addr_plus4      = INSTR_ADDR + 32'd4;

  assign DEC_VALID = (count != '0);
  // Gated so the decode bus reads zero whenever the FIFO is empty, including during reset.
  assign DEC_PC    = DEC_VALID ? mem_pc[rd_ptr]    : 32'h0;
  assign DEC_INSTR = DEC_VALID ? mem_instr[rd_ptr] : 32'h0;

  // A redirect suppresses both the push of any arriving response and a concurrent pop.
  always_comb begin
    push = (state == REQ) && INSTR_VALID && !REDIRECT;
    pop  = DEC_VALID && DEC_READY && !REDIRECT;
    case ({push, pop})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
    has_space = (count_next < CNT_FULL);
  end

  always_ff @(posedge CPU_CLK or posedge CPU_RES) begin
    if (CPU_RES) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (REDIRECT || has_space) state_next = REQ;
      end
      REQ: begin
        if (REDIRECT)         state_next = INSTR_VALID ? REQ : DISCARD;
        else if (INSTR_VALID) state_next = has_space ? REQ : IDLE;
      end
      DISCARD: begin
        if (INSTR_VALID) state_next = REQ;
      end
      default: state_next = IDLE;
    endcase
  end

  // While a request is outstanding the address must hold, so a redirect only
  // retargets fetch_pc until the pending response has been consumed.
  always_comb begin
    addr_load = 1'b0;
    addr_next = INSTR_ADDR;
    pc_load   = 1'b0;
    pc_next   = fetch_pc;
    if (REDIRECT) begin
      pc_load = 1'b1;
      pc_next = redirect_target;
      if (state == IDLE || INSTR_VALID) begin
        addr_load = 1'b1;
        addr_next = redirect_target;
      end
    end else begin
      case (state)
        IDLE: begin
          addr_load = 1'b1;
          addr_next = fetch_pc;
        end
        REQ: begin
          if (INSTR_VALID) begin
            pc_load   = 1'b1;
            pc_next   = addr_plus4;
            addr_load = 1'b1;
            addr_next = addr_plus4;
          end
        end
        DISCARD: begin
          if (INSTR_VALID) begin
            addr_load = 1'b1;
            addr_next = fetch_pc;
          end
        end
        default: begin
          addr_load = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CPU_CLK or posedge CPU_RES) begin
    if (CPU_RES) begin
      INSTR_REQ  <= 1'b0;
      INSTR_ADDR <= 32'h0;
      fetch_pc   <= RESET_PC;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
    end else begin
      INSTR_REQ <= (state_next != IDLE);
      if (addr_load) INSTR_ADDR <= addr_next;
      if (pc_load)   fetch_pc   <= pc_next;
      if (REDIRECT) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        count <= count_next;
      end
    end
  end

  always_ff @(posedge CPU_CLK or posedge CPU_RES) begin
    if (CPU_RES) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]    <= 32'h0;
        mem_instr[i] <= 32'h0;
      end
    end else if (push) begin
      mem_pc[wr_ptr]    <= INSTR_ADDR;
      mem_instr[wr_ptr] <= INSTR_RDATA;
    end
  end

endmodule

// File: tb/tb_edusoc_fetch.sv
// tb/tb_edusoc_fetch.sv - directed self-checking bench for edusoc_fetch
module tb_edusoc_fetch;

  logic        CPU_CLK = 1'b0;
  logic        CPU_RES = 1'b0;
  logic        INSTR_REQ;
  logic [31:0] INSTR_ADDR;
  logic        INSTR_VALID;
  logic [31:0] INSTR_RDATA;
  logic        DEC_VALID;
  logic        DEC_READY = 1'b0;
  logic [31:0] DEC_PC;
  logic [31:0] DEC_INSTR;
  logic        REDIRECT = 1'b0;
  logic [31:0] REDIRECT_PC = 32'h0;

  int vectors     = 0;
  int miscompares = 0;
  int mem_lat     = 0;
  int wcnt        = 0;
  int resp_cnt    = 0;

  localparam logic [31:0] PAT = 32'hA5A5_0000;

  edusoc_fetch #(.RESET_PC(32'h100), .DEPTH(4)) dut (
    .CPU_CLK    (CPU_CLK),
    .CPU_RES    (CPU_RES),
    .INSTR_REQ  (INSTR_REQ),
    .INSTR_ADDR (INSTR_ADDR),
    .INSTR_VALID(INSTR_VALID),
    .INSTR_RDATA(INSTR_RDATA),
    .DEC_VALID  (DEC_VALID),
    .DEC_READY  (DEC_READY),
    .DEC_PC     (DEC_PC),
    .DEC_INSTR  (DEC_INSTR),
    .REDIRECT   (REDIRECT),
    .REDIRECT_PC(REDIRECT_PC)
  );

  always #5 CPU_CLK = ~CPU_CLK;

  // SoC model: answers after mem_lat wait cycles with addr ^ PAT
  assign INSTR_VALID = INSTR_REQ && (wcnt >= mem_lat);
  assign INSTR_RDATA = INSTR_ADDR ^ PAT;

  always @(posedge CPU_CLK) begin
    if (!INSTR_REQ || INSTR_VALID) wcnt <= 0;
    else                           wcnt <= wcnt + 1;
    if (INSTR_REQ && INSTR_VALID && !CPU_RES) resp_cnt <= resp_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CPU_CLK);
    @(negedge CPU_CLK);
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CPU_CLK);
    CPU_RES = 1'b1;
    tick();
    tick();
    CPU_RES = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_pc;
    int n;
    int base;

    // reset state before any clock edge
    #1 CPU_RES = 1'b1;
    #2;
    check1 ("rst_req",   INSTR_REQ,  1'b0);
    check32("rst_addr",  INSTR_ADDR, 32'h0);
    check1 ("rst_valid", DEC_VALID,  1'b0);
    check32("rst_pc",    DEC_PC,     32'h0);
    check32("rst_instr", DEC_INSTR,  32'h0);

    // streaming, zero-wait memory, decode always ready
    DEC_READY = 1'b1;
    mem_lat   = 0;
    @(negedge CPU_CLK);
    CPU_RES = 1'b0;
    tick();
    check1 ("t1_first_req",  INSTR_REQ,  1'b1);
    check32("t1_first_addr", INSTR_ADDR, 32'h100);
    check1 ("t1_empty",      DEC_VALID,  1'b0);
    tick();
    exp_pc = 32'h100;
    for (int i = 0; i < 5; i++) begin
      check1 ("t1_valid", DEC_VALID, 1'b1);
      check32("t1_pc",    DEC_PC,    exp_pc);
      check32("t1_instr", DEC_INSTR, exp_pc ^ PAT);
      check32("t1_addr",  INSTR_ADDR, exp_pc + 32'd4);
      tick();
      exp_pc = exp_pc + 32'd4;
    end

    // back-pressure fills the FIFO, then fetch resumes at 0x110
    DEC_READY = 1'b0;
    do_reset();
    base = resp_cnt;
    for (int i = 0; i < 8; i++) tick();
    check1 ("t2_req_drop", INSTR_REQ, 1'b1 ^ 1'b1);
    check32("t2_accepted", 32'(resp_cnt - base), 32'd4);
    check32("t2_head_pc",  DEC_PC,    32'h100);
    check32("t2_head_ins", DEC_INSTR, 32'h100 ^ PAT);
    DEC_READY = 1'b1;
    tick();
    check1 ("t2_resume_req",  INSTR_REQ,  1'b1);
    check32("t2_resume_addr", INSTR_ADDR, 32'h110);
    exp_pc = 32'h104;
    for (int i = 0; i < 6; i++) begin
      check1 ("t2_valid", DEC_VALID, 1'b1);
      check32("t2_pc",    DEC_PC,    exp_pc);
      tick();
      exp_pc = exp_pc + 32'd4;
    end

    // 3-cycle memory, redirect while the request to 0x104 is outstanding
    mem_lat = 3;
    do_reset();
    n = 0;
    while (INSTR_ADDR !== 32'h104 && n < 20) begin tick(); n++; end
    check32("t3_reach_104", INSTR_ADDR, 32'h104);
    tick();
    REDIRECT    = 1'b1;
    REDIRECT_PC = 32'h203;
    tick();
    REDIRECT = 1'b0;
    check32("t3_stale_hold", INSTR_ADDR, 32'h104);
    check1 ("t3_req_held",   INSTR_REQ,  1'b1);
    check1 ("t3_flushed",    DEC_VALID,  1'b0);
    n = 0;
    while (INSTR_ADDR === 32'h104 && n < 20) begin
      check1("t3_no_stale", DEC_VALID, 1'b0);
      tick();
      n++;
    end
    check32("t3_new_addr", INSTR_ADDR, 32'h200);
    check1 ("t3_dropped",  DEC_VALID,  1'b0);
    n = 0;
    while (DEC_VALID !== 1'b1 && n < 20) begin tick(); n++; end
    check32("t3_dec_pc",    DEC_PC,    32'h200);
    check32("t3_dec_instr", DEC_INSTR, 32'h200 ^ PAT);

    // redirect coinciding with a response and a pop
    mem_lat = 0;
    tick();
    tick();
    tick();
    check1("t4_pre_valid", DEC_VALID,   1'b1);
    check1("t4_pre_resp",  INSTR_VALID, 1'b1);
    REDIRECT    = 1'b1;
    REDIRECT_PC = 32'h400;
    tick();
    REDIRECT = 1'b0;
    check1 ("t4_empty", DEC_VALID,  1'b0);
    check32("t4_addr",  INSTR_ADDR, 32'h400);
    check1 ("t4_req",   INSTR_REQ,  1'b1);
    tick();
    check1 ("t4_valid", DEC_VALID, 1'b1);
    check32("t4_pc",    DEC_PC,    32'h400);

    // address wrap at the top of the 32-bit space
    REDIRECT    = 1'b1;
    REDIRECT_PC = 32'hFFFF_FFF8;
    tick();
    REDIRECT = 1'b0;
    check32("t5_addr0", INSTR_ADDR, 32'hFFFF_FFF8);
    tick();
    check32("t5_addr1", INSTR_ADDR, 32'hFFFF_FFFC);
    check32("t5_pc0",   DEC_PC,     32'hFFFF_FFF8);
    tick();
    check32("t5_addr2", INSTR_ADDR, 32'h0);
    check32("t5_pc1",   DEC_PC,     32'hFFFF_FFFC);
    tick();
    check32("t5_pc2",    DEC_PC,    32'h0);
    check32("t5_instr2", DEC_INSTR, PAT);

    // asynchronous reset with FIFO partially full and a request pending
    DEC_READY = 1'b0;
    tick();
    tick();
    check1("t6_pre_valid", DEC_VALID, 1'b1);
    check1("t6_pre_req",   INSTR_REQ, 1'b1);
    #2 CPU_RES = 1'b1;
    #1;
    check1 ("t6_req",   INSTR_REQ,  1'b0);
    check32("t6_addr",  INSTR_ADDR, 32'h0);
    check1 ("t6_valid", DEC_VALID,  1'b0);
    check32("t6_pc",    DEC_PC,     32'h0);
    check32("t6_instr", DEC_INSTR,  32'h0);
    DEC_READY = 1'b1;
    @(negedge CPU_CLK);
    CPU_RES = 1'b0;
    tick();
    check1 ("t6_restart_req",  INSTR_REQ,  1'b1);
    check32("t6_restart_addr", INSTR_ADDR, 32'h100);
    tick();
    check1 ("t6_restart_valid", DEC_VALID, 1'b1);
    check32("t6_restart_pc",    DEC_PC,    32'h100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
